// File: rtl/conv3x3_stream_if.sv
// Stream interface for conv3x3_stream: pixel input stream plus tagged result stream.
// The engine connects through the slave modport; the pixel source / result sink uses master.
interface conv3x3_stream_if #(
    parameter int PW    = 8,
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_data;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_row, out_col
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_row, out_col
    );
endinterface

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution engine: two line buffers feed a sliding window whose
// valid-region result is registered with its row/col tag under valid/ready flow control.
// Optional feature macro CONV_ABS_EN: negative accumulators give |acc| instead of 0.
module conv3x3_stream #(
    parameter int PW    = 8,
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    output logic             done,
    conv3x3_stream_if.slave  bus
);
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int AW    = PW + 5;
    localparam int TOTAL = IMG_W * IMG_H;
    localparam int NW    = $clog2(TOTAL + 1);

    localparam logic [CW-1:0] LAST_C = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_R = RW'(IMG_H - 1);
    localparam logic [CW-1:0] END_C  = CW'(IMG_W - 2);
    localparam logic [RW-1:0] END_R  = RW'(IMG_H - 2);
    localparam logic signed [AW-1:0] MAXV = AW'((1 << PW) - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, next_state;

    logic [1:0]    mode_q;
    logic [CW-1:0] c;
    logic [RW-1:0] r;
    logic [NW-1:0] pix_cnt;

    logic [PW-1:0] lb0 [0:IMG_W-1];
    logic [PW-1:0] lb1 [0:IMG_W-1];
    logic [PW-1:0] win_l [0:2];
    logic [PW-1:0] win_m [0:2];
    logic [PW-1:0] col_new [0:2];

    logic          out_valid_q;
    logic [PW-1:0] data_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;

    logic in_fire, out_fire, win_full, last_out;
    logic signed [AW-1:0] p [0:2][0:2];
    logic signed [AW-1:0] acc, mag;
    logic [PW-1:0] result;

    assign bus.in_ready  = (state == RUN) && (pix_cnt < NW'(TOTAL)) &&
                           (!out_valid_q || bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_row   = row_q;
    assign bus.out_col   = col_q;

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = out_valid_q && bus.out_ready;
    assign win_full = (r >= RW'(2)) && (c >= CW'(2));
    assign last_out = out_fire && (row_q == END_R) && (col_q == END_C);

    // Incoming column: two rows above from the line buffers, current pixel at the bottom.
    always_comb begin
        col_new[0] = lb1[c];
        col_new[1] = lb0[c];
        col_new[2] = bus.in_data;
    end

    // Zero-extended signed view of the full window, right column taken straight from the input.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            p[i][0] = $signed({{(AW-PW){1'b0}}, win_l[i]});
            p[i][1] = $signed({{(AW-PW){1'b0}}, win_m[i]});
            p[i][2] = $signed({{(AW-PW){1'b0}}, col_new[i]});
        end
    end

    // Kernel arithmetic using shifts only, then sign handling and saturation to PW bits.
    always_comb begin
        acc = '0;
        case (mode_q)
            2'd0: acc = p[1][1];
            2'd1: acc = (p[0][0] + p[0][2] + p[2][0] + p[2][2] +
                         ((p[0][1] + p[1][0] + p[1][2] + p[2][1]) <<< 1) +
                         (p[1][1] <<< 2)) >>> 4;
            2'd2: acc = (p[1][1] <<< 2) + p[1][1] - p[0][1] - p[1][0] - p[1][2] - p[2][1];
            default: acc = p[0][1] + p[1][0] + p[1][2] + p[2][1] - (p[1][1] <<< 2);
        endcase
`ifdef CONV_ABS_EN
        mag = (acc < 0) ? -acc : acc;
`else
        mag = (acc < 0) ? '0 : acc;
`endif
        result = (mag > MAXV) ? MAXV[PW-1:0] : mag[PW-1:0];
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // FSM next state; done is high for the single DONE cycle.
    always_comb begin
        next_state = state;
        done       = 1'b0;
        case (state)
            IDLE: if (start) next_state = RUN;
            RUN:  if (last_out) next_state = DONE;
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Frame counters, latched mode and the registered result stage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q      <= '0;
            c           <= '0;
            r           <= '0;
            pix_cnt     <= '0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
        end else begin
            if (state == IDLE && start) begin
                mode_q  <= mode;
                c       <= '0;
                r       <= '0;
                pix_cnt <= '0;
            end else if (in_fire) begin
                pix_cnt <= pix_cnt + NW'(1);
                if (c == LAST_C) begin
                    c <= '0;
                    r <= (r == LAST_R) ? '0 : r + RW'(1);
                end else begin
                    c <= c + CW'(1);
                end
            end
            if (in_fire && win_full) begin
                out_valid_q <= 1'b1;
                data_q      <= result;
                row_q       <= r - RW'(1);
                col_q       <= c - CW'(1);
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Line buffers and window columns shift only on an accepted pixel; contents need no reset.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            lb1[c] <= lb0[c];
            lb0[c] <= bus.in_data;
            for (int i = 0; i < 3; i++) begin
                win_l[i] <= win_m[i];
                win_m[i] <= col_new[i];
            end
        end
    end
endmodule

// File: tb/tb_conv3x3_stream.sv
// Testbench for conv3x3_stream (8x6 image, 8-bit pixels) with a kernel-table reference model.
// Honours CONV_ABS_EN the same way as the design.
module tb_conv3x3_stream;
    localparam int PW = 8;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int TOTAL = W * H;
`ifdef CONV_ABS_EN
    localparam int ABS_ON = 1;
`else
    localparam int ABS_ON = 0;
`endif
    localparam int LAP_C = ABS_ON ? 200 : 0;
    localparam int SHP_N = ABS_ON ? 200 : 0;

    typedef struct {
        int row;
        int col;
        int data;
    } res_t;

    typedef struct {
        int mode;
        int pat;
        int row;
        int col;
        int exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic done;

    conv3x3_stream_if #(.PW(PW), .IMG_W(W), .IMG_H(H)) bus ();

    conv3x3_stream #(.PW(PW), .IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mode  (mode),
        .done  (done),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int   passed = 0;
    int   total  = 0;
    int   kern [4][3][3];
    int   img [H][W];
    int   got_img [H][W];
    res_t exp_q [$];
    vec_t vecs [20];

    // Single comparison point: every check goes through here.
    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Fill the image according to a named pattern.
    task automatic fill_image(input int pat);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                case (pat)
                    0: img[y][x] = y * W + x;
                    1: img[y][x] = 100;
                    2: img[y][x] = 255;
                    3: img[y][x] = (y == 3 && x == 3) ? 50 : 0;
                    4: img[y][x] = (y == 2 && x == 2) ? 200 : 0;
                    default: img[y][x] = int'($urandom_range(0, 255));
                endcase
    endtask

    // Reference model: direct kernel sum over every valid centre, raster order.
    task automatic build_expected(input int m);
        int acc;
        exp_q.delete();
        for (int y = 1; y < H - 1; y++)
            for (int x = 1; x < W - 1; x++) begin
                acc = 0;
                for (int dy = 0; dy < 3; dy++)
                    for (int dx = 0; dx < 3; dx++)
                        acc += kern[m][dy][dx] * img[y - 1 + dy][x - 1 + dx];
                if (m == 1) acc = acc / 16;
                if (acc < 0) acc = ABS_ON ? -acc : 0;
                if (acc > 255) acc = 255;
                exp_q.push_back('{row: y, col: x, data: acc});
            end
    endtask

    // Drive one cycle of source/sink signals.
    task automatic applyStimulus(input int pix, input bit gaps, input bit hold,
                                 input bit st, input int fmode);
        bus.in_valid  = (pix < TOTAL) && (!gaps || $urandom_range(0, 3) != 0);
        bus.in_data   = (pix < TOTAL) ? 8'(img[pix / W][pix % W]) : 8'd0;
        bus.out_ready = !hold && (!gaps || $urandom_range(0, 2) != 0);
        start         = st;
        mode          = st ? 2'((fmode + 1) % 4) : 2'(fmode);
    endtask

    // Run one frame; optional output stall, ignored mid-frame start, or reset abort.
    task automatic run_frame(input int fmode, input int stall_at, input bit mid_start,
                             input int abort_at, input bit gaps);
        int pix, got, dones, post, stall_left;
        int sd, sr, sc;
        bit stall_done, aborted, idle_ok;
        build_expected(fmode);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                got_img[y][x] = -1;
        @(posedge clk); #1;
        start = 1'b1;
        mode  = 2'(fmode);
        @(posedge clk); #1;
        start = 1'b0;
        pix = 0; got = 0; dones = 0; post = 0; stall_left = 0;
        sd = 0; sr = 0; sc = 0;
        stall_done = 1'b0; aborted = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            applyStimulus(pix, gaps, stall_left > 0, mid_start && cyc == 20, fmode);
            #1;
            if (stall_at >= 0 && !stall_done && stall_left == 0 &&
                bus.out_valid && got == stall_at) begin
                bus.out_ready = 1'b0;
                stall_left = 5;
                stall_done = 1'b1;
                sd = int'(bus.out_data);
                sr = int'(bus.out_row);
                sc = int'(bus.out_col);
                #1;
                checkOutput("stall_in_ready", int'(bus.in_ready), 0);
            end else if (stall_left > 0) begin
                checkOutput("stall_valid", int'(bus.out_valid), 1);
                checkOutput("stall_data", int'(bus.out_data), sd);
                checkOutput("stall_row", int'(bus.out_row), sr);
                checkOutput("stall_col", int'(bus.out_col), sc);
                checkOutput("stall_in_ready", int'(bus.in_ready), 0);
            end
            if (stall_left > 0) stall_left--;
            if (done) dones++;
            if (bus.out_valid && bus.out_ready) begin
                if (got < exp_q.size()) begin
                    checkOutput($sformatf("res%0d_data", got), int'(bus.out_data), exp_q[got].data);
                    checkOutput($sformatf("res%0d_row", got), int'(bus.out_row), exp_q[got].row);
                    checkOutput($sformatf("res%0d_col", got), int'(bus.out_col), exp_q[got].col);
                end
                if (int'(bus.out_row) < H && int'(bus.out_col) < W)
                    got_img[bus.out_row][bus.out_col] = int'(bus.out_data);
                got++;
            end
            if (bus.in_valid && bus.in_ready) pix++;
            if (abort_at >= 0 && pix >= abort_at) begin
                aborted = 1'b1;
                break;
            end
            if (dones > 0) post++;
            if (post > 4) break;
            @(posedge clk); #1;
        end
        if (aborted) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            start = 1'b0;
            reset = 1'b0;
            @(posedge clk); #2;
            checkOutput("mrst_out_valid", int'(bus.out_valid), 0);
            checkOutput("mrst_in_ready", int'(bus.in_ready), 0);
            checkOutput("mrst_done", int'(done), 0);
            checkOutput("mrst_out_data", int'(bus.out_data), 0);
            checkOutput("mrst_out_row", int'(bus.out_row), 0);
            checkOutput("mrst_out_col", int'(bus.out_col), 0);
            reset = 1'b1;
            idle_ok = 1'b1;
            bus.in_valid = 1'b1;
            for (int k = 0; k < 4; k++) begin
                @(posedge clk); #2;
                if (done || bus.out_valid || bus.in_ready) idle_ok = 1'b0;
            end
            bus.in_valid = 1'b0;
            checkOutput("mrst_stays_idle", int'(idle_ok), 1);
        end else begin
            checkOutput("result_count", got, exp_q.size());
            checkOutput("done_pulses", dones, 1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        int cur_mode, cur_pat;
        kern = '{'{'{0, 0, 0}, '{0, 1, 0}, '{0, 0, 0}},
                 '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}},
                 '{'{0, -1, 0}, '{-1, 5, -1}, '{0, -1, 0}},
                 '{'{0, 1, 0}, '{1, -4, 1}, '{0, 1, 0}}};

        vecs[0]  = '{0, 0, 1, 1, 9};
        vecs[1]  = '{0, 0, 2, 3, 19};
        vecs[2]  = '{0, 0, 4, 6, 38};
        vecs[3]  = '{1, 1, 1, 1, 100};
        vecs[4]  = '{1, 1, 4, 6, 100};
        vecs[5]  = '{2, 2, 1, 1, 255};
        vecs[6]  = '{2, 2, 3, 5, 255};
        vecs[7]  = '{3, 3, 3, 3, LAP_C};
        vecs[8]  = '{3, 3, 2, 3, 50};
        vecs[9]  = '{3, 3, 4, 3, 50};
        vecs[10] = '{3, 3, 3, 2, 50};
        vecs[11] = '{3, 3, 3, 4, 50};
        vecs[12] = '{3, 3, 1, 1, 0};
        vecs[13] = '{3, 3, 2, 2, 0};
        vecs[14] = '{2, 4, 2, 2, 255};
        vecs[15] = '{2, 4, 1, 2, SHP_N};
        vecs[16] = '{2, 4, 2, 1, SHP_N};
        vecs[17] = '{2, 4, 2, 3, SHP_N};
        vecs[18] = '{2, 4, 3, 2, SHP_N};
        vecs[19] = '{2, 4, 4, 6, 0};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_out_valid", int'(bus.out_valid), 0);
        checkOutput("rst_in_ready", int'(bus.in_ready), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_out_data", int'(bus.out_data), 0);
        checkOutput("rst_out_row", int'(bus.out_row), 0);
        checkOutput("rst_out_col", int'(bus.out_col), 0);
        @(posedge clk); #1;
        reset = 1'b1;

        cur_mode = -1;
        cur_pat  = -1;
        for (int i = 0; i < 20; i++) begin
            if (vecs[i].mode != cur_mode || vecs[i].pat != cur_pat) begin
                $display("[TB] frame mode %0d pattern %0d", vecs[i].mode, vecs[i].pat);
                fill_image(vecs[i].pat);
                run_frame(vecs[i].mode, (vecs[i].pat == 0) ? 10 : -1, 1'b0, -1, vecs[i].pat != 0);
                cur_mode = vecs[i].mode;
                cur_pat  = vecs[i].pat;
            end
            checkOutput($sformatf("vec%0d_r%0d_c%0d", i, vecs[i].row, vecs[i].col),
                        got_img[vecs[i].row][vecs[i].col], vecs[i].exp);
        end

        for (int k = 0; k < 3; k++) begin
            fill_image(5);
            run_frame(int'($urandom_range(0, 3)), -1, 1'b0, -1, 1'b1);
        end

        $display("[TB] reset mid-frame");
        fill_image(0);
        run_frame(0, -1, 1'b0, 30, 1'b0);

        $display("[TB] frame with ignored mid-run start");
        fill_image(5);
        run_frame(3, -1, 1'b1, -1, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
